// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: request/grant bundle between the AHB masters and the arbiter.
// In: Hbusreq, Hlock, Htrans, Hburst, Hready. Out: Hgrant, Hmaster, Hmastlock.
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif
`ifndef MASTER_WIDTH
`define MASTER_WIDTH 2
`endif

interface ahb_arbiter_if #(
  parameter int NUM_MASTERS  = `NUM_MASTERS,
  parameter int MASTER_WIDTH = `MASTER_WIDTH
);
  logic [NUM_MASTERS-1:0]  Hbusreq;
  logic [NUM_MASTERS-1:0]  Hlock;
  logic [1:0]              Htrans;
  logic [2:0]              Hburst;
  logic                    Hready;
  logic [NUM_MASTERS-1:0]  Hgrant;
  logic [MASTER_WIDTH-1:0] Hmaster;
  logic                    Hmastlock;

  modport master (
    output Hbusreq, Hlock, Htrans, Hburst, Hready,
    input  Hgrant, Hmaster, Hmastlock
  );

  modport slave (
    input  Hbusreq, Hlock, Htrans, Hburst, Hready,
    output Hgrant, Hmaster, Hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with burst and locked-transfer hold.
// Ports: Hclk, Hreset (async, active-high); bus (ahb_arbiter_if.slave).
// Optional macro AHB_ARB_PARK_EN: park the grant on master 0 when idle.
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif
`ifndef MASTER_WIDTH
`define MASTER_WIDTH 2
`endif

module ahb_arbiter #(
  parameter int NUM_MASTERS  = `NUM_MASTERS,
  parameter int MASTER_WIDTH = `MASTER_WIDTH
) (
  input logic          Hclk,
  input logic          Hreset,
  ahb_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_OWN, S_BURST, S_LOCKED
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

`ifdef AHB_ARB_PARK_EN
  localparam logic [NUM_MASTERS-1:0] GNT_IDLE = NUM_MASTERS'(1);
`else
  localparam logic [NUM_MASTERS-1:0] GNT_IDLE = '0;
`endif

  localparam logic [MASTER_WIDTH-1:0] PTR_RST =
    MASTER_WIDTH'(NUM_MASTERS - 1);

  state_e                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [MASTER_WIDTH-1:0] gidx_q, gidx_d;
  logic [MASTER_WIDTH-1:0] ptr_q, ptr_d;
  logic [MASTER_WIDTH-1:0] master_q, master_d;
  logic                    mastlock_q, mastlock_d;
  logic [3:0]              cnt_q, cnt_d;

  logic                    win_found;
  logic [MASTER_WIDTH-1:0] win_idx;
  logic [MASTER_WIDTH-1:0] cand;
  logic                    do_arb;
  logic                    own_eval;
  logic [3:0]              blen;

  logic tr_idle, tr_nonseq, tr_seq;
  logic fixed_burst, single;
  logic own_req, own_lock;

  assign tr_idle     = bus.Htrans == TR_IDLE;
  assign tr_nonseq   = bus.Htrans == TR_NONSEQ;
  assign tr_seq      = bus.Htrans == TR_SEQ;
  assign fixed_burst = bus.Hburst[2:1] != 2'b00;
  assign single      = bus.Hburst == 3'b000;
  assign own_req     = bus.Hbusreq[gidx_q];
  assign own_lock    = bus.Hlock[gidx_q];

  always_comb begin
    unique case (bus.Hburst[2:1])
      2'b01:   blen = 4'd3;
      2'b10:   blen = 4'd7;
      2'b11:   blen = 4'd15;
      default: blen = 4'd0;
    endcase
  end

  // Search starts one past the last winner so every requester is reached.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MASTER_WIDTH'((int'(ptr_q) + i) % NUM_MASTERS);
      if (!win_found && bus.Hbusreq[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    do_arb   = 1'b0;
    own_eval = 1'b0;
    if (bus.Hready) begin
      unique case (state_q)
        S_IDLE: do_arb = 1'b1;
        S_OWN:  own_eval = 1'b1;
        S_BURST: begin
          // Early termination falls back to the ownership rules.
          if (tr_idle || tr_nonseq) begin
            cnt_d    = '0;
            own_eval = 1'b1;
          end else if (cnt_q == 4'd0) begin
            do_arb = 1'b1;
          end else if (tr_seq) begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_LOCKED: begin
          if (!own_lock && tr_idle)
            do_arb = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
      if (own_eval) begin
        if (tr_nonseq && own_lock) begin
          state_d = S_LOCKED;
        end else if (tr_nonseq && fixed_burst) begin
          state_d = S_BURST;
          cnt_d   = blen;
        end else if (tr_idle || (tr_nonseq && single) || !own_req) begin
          do_arb = 1'b1;
        end else begin
          state_d = S_OWN;
        end
      end
      if (do_arb) begin
        if (win_found) begin
          state_d          = S_OWN;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          ptr_d            = win_idx;
        end else begin
          state_d = S_IDLE;
          grant_d = GNT_IDLE;
          gidx_d  = '0;
        end
      end
    end
  end

  // Address-phase owner follows the grant one accepted cycle later.
  always_comb begin
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (bus.Hready) begin
      if (|grant_q) begin
        master_d   = gidx_q;
        mastlock_d = bus.Hlock[gidx_q];
      end else begin
        mastlock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q    <= S_IDLE;
      grant_q    <= GNT_IDLE;
      gidx_q     <= '0;
      ptr_q      <= PTR_RST;
      master_q   <= '0;
      mastlock_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.Hgrant    = grant_q;
  assign bus.Hmaster   = master_q;
  assign bus.Hmastlock = mastlock_q;
endmodule
